// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared MEM widths, sync marker and loader FSM states
package uart_loader_pkg;
  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 8;
  localparam int LEN_W = 14;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, LOAD, FINISH} state_t;
endpackage

// File: rtl/uart_mem_loader_gap_timer.sv
// gap_timer: counts idle cycles between bytes, flags expiry at TIMEOUT_CYCLES-1
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count;
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable) count <= count + CW'(1);
  end
  assign expired = enable && !clear && count == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: parses sync/length/payload frames from UART RX into sequential MEM writes
module uart_mem_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] write_select,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  loaded_count
);
  state_t state, state_n;
  logic [LEN_W-1:0] len;
  logic [ADDR_W-1:0] addr;
  logic active, expired, sync_fire, bad_len, load_fire, last_byte, lo_zero;
  assign active = state inside {LEN_HI, LEN_LO, LOAD};
  assign busy = state != IDLE;
  assign sync_fire = state == IDLE && rx_valid && rx_data == SYNC_BYTE;
  assign bad_len = state == LEN_HI && rx_valid && rx_data[DATA_W-1:DATA_W-2] != '0;
  assign load_fire = state == LOAD && rx_valid;
  assign last_byte = loaded_count + LEN_W'(1) == len;
  assign lo_zero = {len[LEN_W-1:DATA_W], rx_data} == '0;
  gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid || !active),
    .enable  (active),
    .expired (expired)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = sync_fire ? LEN_HI : IDLE;
      LEN_HI:  state_n = expired ? IDLE : !rx_valid ? LEN_HI : bad_len ? IDLE : LEN_LO;
      LEN_LO:  state_n = expired ? IDLE : !rx_valid ? LEN_LO : lo_zero ? FINISH : LOAD;
      LOAD:    state_n = expired ? IDLE : (load_fire && last_byte) ? FINISH : LOAD;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      addr         <= '0;
      loaded_count <= '0;
      error        <= 1'b0;
      done         <= 1'b0;
      wr_enable    <= 1'b0;
      write_select <= '0;
      write_data   <= '0;
    end else begin
      state     <= state_n;
      done      <= state == FINISH;
      wr_enable <= load_fire;
      if (sync_fire) begin
        error        <= 1'b0;
        loaded_count <= '0;
      end
      if (bad_len || expired) error <= 1'b1;
      if (state == LEN_HI && rx_valid) len[LEN_W-1:DATA_W] <= rx_data[LEN_W-DATA_W-1:0];
      if (state == LEN_LO && rx_valid) begin
        len[DATA_W-1:0] <= rx_data;
        addr            <= BASE_ADDR;
      end
      if (load_fire) begin
        write_select <= addr;
        write_data   <= rx_data;
        addr         <= addr + ADDR_W'(1);
        loaded_count <= loaded_count + LEN_W'(1);
      end
    end
  end
endmodule
